mat_res_serializer: RTL and testbench

//  Receives the packed 2x2 result matrix from the parallel matrix multiplier and

---
 rtl/mat_res_serializer_if.sv | 41 ++++
 rtl/mat_res_serializer.sv | 207 ++++++++++++++++++++
 tb/tb_mat_res_serializer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mat_res_serializer_if.sv
// mat_res_serializer_if: matrix result bus in, element stream out, and status.
// The serializer connects through the master modport. The producer, the consumer
// and the control logic connect through the slave modport.
// Optional feature macro: MAT_RES_DROP_CNT_EN adds the 8-bit drop_cnt status field.
interface mat_res_serializer_if #(
    parameter int ELEM_W = 16
);
    logic [4*ELEM_W-1:0] res_in;
    logic                res_valid;
    logic [ELEM_W-1:0]   out_data;
    logic [1:0]          out_idx;
    logic                out_last;
    logic                out_valid;
    logic                out_ready;
    logic                busy;
    logic                ovf;
    logic                clr_ovf;
`ifdef MAT_RES_DROP_CNT_EN
    logic [7:0]          drop_cnt;

    modport master (
        input  res_in, res_valid, out_ready, clr_ovf,
        output out_data, out_idx, out_last, out_valid, busy, ovf, drop_cnt
    );

    modport slave (
        output res_in, res_valid, out_ready, clr_ovf,
        input  out_data, out_idx, out_last, out_valid, busy, ovf, drop_cnt
    );
`else
    modport master (
        input  res_in, res_valid, out_ready, clr_ovf,
        output out_data, out_idx, out_last, out_valid, busy, ovf
    );

    modport slave (
        output res_in, res_valid, out_ready, clr_ovf,
        input  out_data, out_idx, out_last, out_valid, busy, ovf
    );
`endif
endinterface

// File: rtl/mat_res_serializer.sv
// mat_res_serializer: buffers whole 2x2 result matrices in a small FIFO and
// streams them out one element per valid/ready handshake.
// The element order is R00, R01, R10, R11.
// The FIFO head stays in place while it is being streamed. It is popped on the
// idx-3 handshake, so a full FIFO can accept a new matrix in that same cycle.
// Optional feature macro: MAT_RES_DROP_CNT_EN adds a saturating drop counter.
module mat_res_serializer #(
    parameter int ELEM_W     = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mat_res_serializer_if.master bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = 4 * ELEM_W;

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    // Select one element of a packed matrix. Element 0 is R00, which sits in the MSBs.
    function automatic logic [ELEM_W-1:0] elem_sel(input logic [WORD_W-1:0] word,
                                                   input logic [1:0] idx);
        logic [ELEM_W-1:0] e;
        case (idx)
            2'd0:    e = word[4*ELEM_W-1:3*ELEM_W];
            2'd1:    e = word[3*ELEM_W-1:2*ELEM_W];
            2'd2:    e = word[2*ELEM_W-1:ELEM_W];
            default: e = word[ELEM_W-1:0];
        endcase
        return e;
    endfunction

    // Saturating increment for the 8-bit drop counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   rd_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ELEM_W-1:0]  data_q, data_d;
    logic [1:0]         idx_q, idx_d;
    logic               last_q, last_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;
`ifdef MAT_RES_DROP_CNT_EN
    logic [7:0]         drop_cnt_q, drop_cnt_d;
`endif

    logic               hs;
    logic               pop;
    logic               push;
    logic               drop;
    logic               full;

    assign rd_nxt = rd_ptr_q + PTR_W'(1);
    assign full   = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign hs     = valid_q & bus.out_ready;
    assign pop    = hs & (idx_q == 2'd3);
    assign push   = bus.res_valid & (~full | pop);
    assign drop   = bus.res_valid & ~push;

    // FIFO pointers and occupancy, together with the overflow bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_nxt;
        end
        // A drop in the same cycle as a clear leaves ovf set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

`ifdef MAT_RES_DROP_CNT_EN
    // Drop counter: a clear restarts the count, and a drop in the same cycle counts as one.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (bus.clr_ovf) begin
            drop_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            drop_cnt_d = sat_inc8(drop_cnt_q);
        end
    end
`endif

    // Serializer FSM: next state and the next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                // A matrix pushed this cycle is presented on the next cycle.
                if ((cnt_q != '0) || push) begin
                    state_d = ST_SEND;
                    valid_d = 1'b1;
                    idx_d   = 2'd0;
                    last_d  = 1'b0;
                    data_d  = elem_sel((cnt_q != '0) ? mem_q[rd_ptr_q] : bus.res_in, 2'd0);
                end
            end
            ST_SEND: begin
                if (hs) begin
                    if (idx_q != 2'd3) begin
                        idx_d  = idx_q + 2'd1;
                        last_d = (idx_q == 2'd2);
                        data_d = elem_sel(mem_q[rd_ptr_q], idx_q + 2'd1);
                    end else if (cnt_q > CNT_W'(1)) begin
                        // Another matrix is already queued behind the head.
                        idx_d  = 2'd0;
                        last_d = 1'b0;
                        data_d = elem_sel(mem_q[rd_nxt], 2'd0);
                    end else if (push) begin
                        // The FIFO empties this cycle, but a new matrix arrives in the same cycle.
                        idx_d  = 2'd0;
                        last_d = 1'b0;
                        data_d = elem_sel(bus.res_in, 2'd0);
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        idx_d   = 2'd0;
                        last_d  = 1'b0;
                        data_d  = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign busy_d = (cnt_d != '0) | valid_d;

    // State, FIFO control and output registers. Reset clears them immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            idx_q    <= '0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef MAT_RES_DROP_CNT_EN
    // Drop counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

    // FIFO storage is written only on an accepted matrix. It needs no reset because occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.res_in;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mat_res_serializer.sv
// tb_mat_res_serializer: directed vectors for mat_res_serializer.
// A queue-based model predicts the stream, and literal expectations pin down key cycles.
module tb_mat_res_serializer;
    localparam int W     = 16;
    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic [63:0] res_in;
    logic        res_valid;
    logic        out_ready;
    logic        clr_ovf;
    bit          chk_en;

    int total;
    int bad;

    mat_res_serializer_if #(.ELEM_W(W)) bus ();

    assign bus.res_in    = res_in;
    assign bus.res_valid = res_valid;
    assign bus.out_ready = out_ready;
    assign bus.clr_ovf   = clr_ovf;

    mat_res_serializer #(.ELEM_W(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [63:0] fq[$];
    int          m_idx;
    bit          m_valid;
    bit          m_ovf;
    int          m_drop;
    bit          m_hs, m_pop, m_push, m_drp;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            fq.delete();
            m_idx   = 0;
            m_valid = 0;
            m_ovf   = 0;
            m_drop  = 0;
        end else begin
            m_hs   = m_valid && out_ready;
            m_pop  = m_hs && (m_idx == 3);
            m_push = res_valid && ((fq.size() < DEPTH) || m_pop);
            m_drp  = res_valid && !m_push;
            if (m_pop) void'(fq.pop_front());
            if (m_push) fq.push_back(res_in);
            if (m_hs && m_idx != 3) begin
                m_idx = m_idx + 1;
            end else if (m_pop || !m_valid) begin
                m_valid = (fq.size() != 0);
                m_idx   = 0;
            end
            if (m_drp) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            if (clr_ovf) m_drop = m_drp ? 1 : 0;
            else if (m_drp && m_drop < 255) m_drop = m_drop + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    logic [63:0] head;
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_valid", {63'd0, bus.out_valid}, {63'd0, m_valid});
            check("m_busy", {63'd0, bus.busy}, {63'd0, (fq.size() != 0) || m_valid});
            check("m_ovf", {63'd0, bus.ovf}, {63'd0, m_ovf});
`ifdef MAT_RES_DROP_CNT_EN
            check("m_drop_cnt", {56'd0, bus.drop_cnt}, 64'(m_drop));
`endif
            if (m_valid) begin
                if (fq.size() == 0) begin
                    check("m_queue_nonempty", 64'd0, 64'd1);
                end else begin
                    head = fq[0];
                    check("m_data", {48'd0, bus.out_data}, {48'd0, head[63 - 16*m_idx -: 16]});
                    check("m_idx", {62'd0, bus.out_idx}, 64'(m_idx));
                    check("m_last", {63'd0, bus.out_last}, {63'd0, m_idx == 3});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] m);
        res_in    = m;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    logic [15:0] exp3 [8] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003,
                              16'hB000, 16'hB001, 16'hB002, 16'hB003};
    logic [15:0] exp4 [8] = '{16'hC100, 16'hC101, 16'hC102, 16'hC103,
                              16'hD000, 16'hD001, 16'hD002, 16'hD003};
    logic [15:0] exp5 [8] = '{16'hE000, 16'hE001, 16'hE002, 16'hE003,
                              16'hF000, 16'hF001, 16'hF002, 16'hF003};

    initial begin
        total     = 0;
        bad       = 0;
        chk_en    = 0;
        reset     = 1'b0;
        res_in    = '0;
        res_valid = 1'b0;
        out_ready = 1'b1;
        clr_ovf   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_ovf", {63'd0, bus.ovf}, 64'd0);
        check("rst_data", {48'd0, bus.out_data}, 64'd0);
        check("rst_idx", {62'd0, bus.out_idx}, 64'd0);
        check("rst_last", {63'd0, bus.out_last}, 64'd0);
        reset  = 1'b1;
        chk_en = 1;
        tick();

        // 1: single matrix, latency and last flag
        send(64'h0001_0002_0003_0004);
        check("t1_valid0", {63'd0, bus.out_valid}, 64'd1);
        check("t1_data0", {48'd0, bus.out_data}, 64'h1);
        check("t1_last0", {63'd0, bus.out_last}, 64'd0);
        tick();
        check("t1_data1", {48'd0, bus.out_data}, 64'h2);
        tick();
        check("t1_data2", {48'd0, bus.out_data}, 64'h3);
        tick();
        check("t1_data3", {48'd0, bus.out_data}, 64'h4);
        check("t1_idx3", {62'd0, bus.out_idx}, 64'd3);
        check("t1_last3", {63'd0, bus.out_last}, 64'd1);
        tick();
        check("t1_busy_end", {63'd0, bus.busy}, 64'd0);
        check("t1_valid_end", {63'd0, bus.out_valid}, 64'd0);

        // 2: backpressure at idx 1
        send(64'h0001_0002_0003_0004);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_hold_data", {48'd0, bus.out_data}, 64'h2);
            check("t2_hold_idx", {62'd0, bus.out_idx}, 64'd1);
        end
        out_ready = 1'b1;
        tick();
        check("t2_resume2", {48'd0, bus.out_data}, 64'h3);
        tick();
        check("t2_resume3", {48'd0, bus.out_data}, 64'h4);
        tick();

        // 3: overflow with three strobes while stalled
        out_ready = 1'b0;
        send(64'hA000_A001_A002_A003);
        send(64'hB000_B001_B002_B003);
        send(64'hC000_C001_C002_C003);
        check("t3_ovf", {63'd0, bus.ovf}, 64'd1);
`ifdef MAT_RES_DROP_CNT_EN
        check("t3_drop_cnt", {56'd0, bus.drop_cnt}, 64'd1);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t3_drain", {48'd0, bus.out_data}, {48'd0, exp3[i]});
            tick();
        end
        check("t3_empty", {63'd0, bus.out_valid}, 64'd0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t3_clr", {63'd0, bus.ovf}, 64'd0);

        // 4: push into a full FIFO on the idx-3 handshake
        out_ready = 1'b0;
        send(64'hB100_B101_B102_B103);
        send(64'hC100_C101_C102_C103);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        check("t4_at_idx3", {62'd0, bus.out_idx}, 64'd3);
        send(64'hD000_D001_D002_D003);
        check("t4_ovf", {63'd0, bus.ovf}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            check("t4_stream", {48'd0, bus.out_data}, {48'd0, exp4[i]});
            check("t4_valid", {63'd0, bus.out_valid}, 64'd1);
            tick();
        end
        check("t4_empty", {63'd0, bus.out_valid}, 64'd0);

        // 5: back-to-back matrices, no bubble
        send(64'hE000_E001_E002_E003);
        for (int i = 0; i < 8; i++) begin
            check("t5_valid", {63'd0, bus.out_valid}, 64'd1);
            check("t5_data", {48'd0, bus.out_data}, {48'd0, exp5[i]});
            if (i == 0) begin
                res_in    = 64'hF000_F001_F002_F003;
                res_valid = 1'b1;
            end
            tick();
            res_valid = 1'b0;
        end
        check("t5_empty", {63'd0, bus.out_valid}, 64'd0);

        // 7: drop and clr_ovf in the same cycle
        out_ready = 1'b0;
        send(64'h1100_1101_1102_1103);
        send(64'h2200_2201_2202_2203);
        send(64'h3300_3301_3302_3303);
        res_in    = 64'h4400_4401_4402_4403;
        res_valid = 1'b1;
        clr_ovf   = 1'b1;
        tick();
        res_valid = 1'b0;
        clr_ovf   = 1'b0;
        check("t7_ovf", {63'd0, bus.ovf}, 64'd1);
`ifdef MAT_RES_DROP_CNT_EN
        check("t7_drop_cnt", {56'd0, bus.drop_cnt}, 64'd1);
`endif

        // 6: reset in the middle of a transfer
        out_ready = 1'b1;
        tick();
        tick();
        check("t6_idx2", {62'd0, bus.out_idx}, 64'd2);
        reset = 1'b0;
        #1;
        check("t6_valid", {63'd0, bus.out_valid}, 64'd0);
        check("t6_busy", {63'd0, bus.busy}, 64'd0);
        check("t6_ovf", {63'd0, bus.ovf}, 64'd0);
`ifdef MAT_RES_DROP_CNT_EN
        check("t6_drop_cnt", {56'd0, bus.drop_cnt}, 64'd0);
`endif
        tick();
        reset = 1'b1;
        tick();
        check("t6_idle", {63'd0, bus.out_valid}, 64'd0);
        send(64'h5500_5501_5502_5503);
        check("t6_fresh_valid", {63'd0, bus.out_valid}, 64'd1);
        check("t6_fresh_idx", {62'd0, bus.out_idx}, 64'd0);
        check("t6_fresh_data", {48'd0, bus.out_data}, 64'h5500);
        repeat (6) tick();
        check("t6_done", {63'd0, bus.busy}, 64'd0);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
